jtag_l2_test: RTL and testbench
===============================

Name: jtag_l2_test

Overview:
- Self-contained JTAG-to-L2 test block: an IEEE 1149.1 TAP plus a small word-addressed L2 SRAM written and read through a JTAG data register.
- Sits at top level as a JTAG-accessible memory test target; the bench drives the JTAG pins and checks L2 read-back.
- All logic runs on clk_i. JTAG pins are oversampled; the TAP advances on detected TCK edges.

Parameters:
- IDCODE_VAL, 32'h1000_0DB3, value captured by IDCODE instruction (bit0 = 1).
- L2_WORDS, 256, number of 32-bit L2 words (power of 2).
- IR_W, 5, instruction register width.

Ports:
- clk_i  in  1  system clock; must be >= 8x TCK frequency.
- rst_i  in  1  synchronous reset, active-high; resets the L2 access engine only (TAP, IR and CONFREG are not reset by it).
- jtag_tck_i  in  1  JTAG test clock (asynchronous, sampled).
- jtag_trst_ni  in  1  JTAG TAP reset, active-low (sampled).
- jtag_tms_i  in  1  test mode select.
- jtag_tdi_i  in  1  test data in.
- jtag_tdo_o  out  1  test data out; reset value 0.

Behaviour:
- Sampling:
  - tck, tms, tdi and trst_n pass through 2-FF synchronizers on clk_i.
  - TCK rising edge = rise_p pulse; falling edge = fall_p pulse.
  - tms and tdi are sampled from the synchronized copies at rise_p.
- TAP reset: synchronized trst_n low forces Test-Logic-Reset, IR = IDCODE, tdo = 0, CONFREG = 0. Five consecutive TMS=1 on rise_p also reaches Test-Logic-Reset.
- TAP FSM: standard 16 states (TLR, RTI, Sel-DR/IR, Capture, Shift, Exit1, Pause, Exit2, Update for DR and IR). Transitions occur only on rise_p.
- Shift rules:
  - Capture loads the selected register; Shift shifts right (tdi into MSB, LSB out); Update latches.
  - jtag_tdo_o is updated on fall_p with the shift-register LSB while in Shift-IR/Shift-DR; otherwise 0.
- IR (5 bits): Capture-IR loads 5'b00101; Update-IR latches.
- Instructions (any other code behaves as BYPASS):
  - 5'h01 IDCODE: 32-bit DR, captures IDCODE_VAL.
  - 5'h06 CONFREG: 9-bit DR. Capture loads the current CONFREG value so the old value shifts out; Update writes CONFREG. Held internally.
  - 5'h08 MEMACC: 65-bit DR, field layout below.
  - 5'h1F BYPASS: 1-bit DR, captures 0.
- MEMACC update fields (bit0 = we, bits[32:1] = addr, bits[64:33] = wdata):
  - At Update-DR, one request pulse is issued to the L2 engine.
  - L2 index = addr[log2(L2_WORDS)+1:2]. Upper address bits are ignored (aliasing); addr[1:0] is ignored.
- MEMACC capture fields: bit0 = done, bits[32:1] = last addr, bits[64:33] = rdata.
- L2 engine (clk_i domain):
  - Write: mem[idx] <= wdata; done <= 1.
  - Read: rdata <= mem[idx]; done <= 1.
  - Latency: 2 clk_i cycles after Update-DR, well before the next Capture.
  - While rst_i = 1: requests are dropped, done = 0, rdata = 0. Reset mid-access aborts the access (no write).
  - A new request clears done until it completes. SRAM contents are not reset.
- Read protocol: scan MEMACC with we=0 and the target addr, pass Update, then scan MEMACC again; that capture returns the data.
- Simultaneous trst_n low and pending L2 request: the request still completes; the TAP resets.

Test Plan:
- trst_n low 5 TCK, then TMS=1 x5 -> TLR, tdo = 0, IR = 5'h01.
- BYPASS: shift 8'b1011_0010 through DR -> tdo returns the same pattern delayed by 1 TCK, first bit 0.
- IDCODE after reset: Shift-DR 32 bits -> 32'h1000_0DB3 LSB first.
- CONFREG: shift in 9'b0_0000_0010 with rst_i = 1 -> shifted-out value 0; second scan returns 9'h002.
- rst_i=0, MEMACC write addr 0 data 32'hABBA_ABBA, then read addr 0 -> captured rdata 32'hABBA_ABBA, done = 1.
- Write addr 32'h400 data 32'h1234_5678, read addr 0 -> 32'h1234_5678 (alias). Write while rst_i = 1 -> done = 0, memory unchanged.

Source files
------------

// File: rtl/jtag_l2_test.sv
// jtag_l2_test: oversampled IEEE 1149.1 TAP with IDCODE, CONFREG, BYPASS and a
// MEMACC data register that issues word reads/writes into a small on-chip L2.
module jtag_l2_test #(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0DB3,
  parameter int unsigned L2_WORDS   = 256,
  parameter int unsigned IR_W       = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic jtag_tck_i,
  input  logic jtag_trst_ni,
  input  logic jtag_tms_i,
  input  logic jtag_tdi_i,
  output logic jtag_tdo_o
);

  localparam int unsigned AW = $clog2(L2_WORDS);

  localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(5'h01);
  localparam logic [IR_W-1:0] IR_CONFREG = IR_W'(5'h06);
  localparam logic [IR_W-1:0] IR_MEMACC  = IR_W'(5'h08);
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(5'b00101);

  typedef enum logic [3:0] {
    S_TLR    = 4'd0,  S_RTI    = 4'd1,  S_SEL_DR = 4'd2,  S_CAP_DR = 4'd3,
    S_SH_DR  = 4'd4,  S_EX1_DR = 4'd5,  S_PAU_DR = 4'd6,  S_EX2_DR = 4'd7,
    S_UPD_DR = 4'd8,  S_SEL_IR = 4'd9,  S_CAP_IR = 4'd10, S_SH_IR  = 4'd11,
    S_EX1_IR = 4'd12, S_PAU_IR = 4'd13, S_EX2_IR = 4'd14, S_UPD_IR = 4'd15
  } tap_state_e;

  logic [1:0]      r_tck_s, r_tms_s, r_tdi_s, r_trst_s;
  logic            r_tck_q;
  logic            w_rise, w_fall, w_tms, w_tdi, w_trst_n;
  tap_state_e      r_state, w_state_nxt;
  logic [IR_W-1:0] r_ir, r_ir_sr;
  logic [64:0]     r_dr, w_dr_cap, w_dr_shift;
  logic [8:0]      r_confreg;
  logic            r_tdo;
  logic            w_upd_mem;
  logic            r_busy, r_done, r_op_we;
  logic [AW-1:0]   r_op_idx;
  logic [31:0]     r_op_wdata, r_rdata, r_last_addr;
  logic [31:0]     r_mem [L2_WORDS];

  // Two-flop synchronizers for all JTAG pins plus a delayed TCK for edge detection
  always_ff @(posedge clk_i) begin
    r_tck_s  <= {r_tck_s[0], jtag_tck_i};
    r_tms_s  <= {r_tms_s[0], jtag_tms_i};
    r_tdi_s  <= {r_tdi_s[0], jtag_tdi_i};
    r_trst_s <= {r_trst_s[0], jtag_trst_ni};
    r_tck_q  <= r_tck_s[1];
  end

  assign w_rise   = r_tck_s[1] & ~r_tck_q;
  assign w_fall   = ~r_tck_s[1] & r_tck_q;
  assign w_tms    = r_tms_s[1];
  assign w_tdi    = r_tdi_s[1];
  assign w_trst_n = r_trst_s[1];

  // TAP next-state decode
  always_comb begin
    w_state_nxt = S_TLR;
    case (r_state)
      S_TLR:    w_state_nxt = w_tms ? S_TLR    : S_RTI;
      S_RTI:    w_state_nxt = w_tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: w_state_nxt = w_tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: w_state_nxt = w_tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  w_state_nxt = w_tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: w_state_nxt = w_tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: w_state_nxt = w_tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: w_state_nxt = w_tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: w_state_nxt = w_tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: w_state_nxt = w_tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: w_state_nxt = w_tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  w_state_nxt = w_tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: w_state_nxt = w_tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: w_state_nxt = w_tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: w_state_nxt = w_tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: w_state_nxt = w_tms ? S_SEL_DR : S_RTI;
      default:  w_state_nxt = S_TLR;
    endcase
  end

  // Capture value and shifted value of the DR selected by the current instruction;
  // one 65-bit register serves all DRs, tdi enters at the MSB of the active length
  always_comb begin
    w_dr_cap   = '0;
    w_dr_shift = {1'b0, r_dr[64:1]};
    case (r_ir)
      IR_IDCODE: begin
        w_dr_cap[31:0] = IDCODE_VAL;
        w_dr_shift[31] = w_tdi;
      end
      IR_CONFREG: begin
        w_dr_cap[8:0] = r_confreg;
        w_dr_shift[8] = w_tdi;
      end
      IR_MEMACC: begin
        w_dr_cap       = {r_rdata, r_last_addr, r_done};
        w_dr_shift[64] = w_tdi;
      end
      default: w_dr_shift[0] = w_tdi;
    endcase
  end

  // TAP state, IR/DR capture-shift-update and TDO launch on TCK falling edge
  always_ff @(posedge clk_i) begin
    if (!w_trst_n) begin
      r_state   <= S_TLR;
      r_ir      <= IR_IDCODE;
      r_tdo     <= 1'b0;
      r_confreg <= '0;
    end else begin
      if (w_rise) begin
        r_state <= w_state_nxt;
        case (r_state)
          S_TLR:    r_ir <= IR_IDCODE;
          S_CAP_IR: r_ir_sr <= IR_CAPTURE;
          S_SH_IR:  r_ir_sr <= {w_tdi, r_ir_sr[IR_W-1:1]};
          S_UPD_IR: r_ir <= r_ir_sr;
          S_CAP_DR: r_dr <= w_dr_cap;
          S_SH_DR:  r_dr <= w_dr_shift;
          S_UPD_DR: if (r_ir == IR_CONFREG) r_confreg <= r_dr[8:0];
          default: ;
        endcase
      end
      if (w_fall) begin
        if (r_state == S_SH_DR)      r_tdo <= r_dr[0];
        else if (r_state == S_SH_IR) r_tdo <= r_ir_sr[0];
        else                         r_tdo <= 1'b0;
      end
    end
  end

  assign jtag_tdo_o = r_tdo;

  assign w_upd_mem = w_trst_n & w_rise & (r_state == S_UPD_DR) & (r_ir == IR_MEMACC);

  // Remember the address of the most recent MEMACC update for read-back
  always_ff @(posedge clk_i) begin
    if (w_upd_mem) r_last_addr <= r_dr[32:1];
  end

  // L2 access engine: accept a request, perform it on the following cycle.
  // Deliberately independent of trst_n so an in-flight access still completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rdata <= '0;
    end else if (r_busy) begin
      r_busy <= 1'b0;
      r_done <= 1'b1;
      if (!r_op_we) r_rdata <= r_mem[r_op_idx];
    end else if (w_upd_mem) begin
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_op_we    <= r_dr[0];
      r_op_idx   <= r_dr[AW+2:3];
      r_op_wdata <= r_dr[64:33];
    end
  end

  // SRAM write port; contents are never reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && r_busy && r_op_we) r_mem[r_op_idx] <= r_op_wdata;
  end

endmodule

// File: tb/tb_jtag_l2_test.sv
// Directed bench for jtag_l2_test: drives JTAG pins at TCK = clk/10 and checks
// scanned-out register contents against hand-computed values.
module tb_jtag_l2_test;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck = 1'b0;
  logic trst_n = 1'b0;
  logic tms = 1'b1;
  logic tdi = 1'b0;
  logic tdo;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [31:0] IDCODE = 32'h1000_0DB3;

  jtag_l2_test #(.IDCODE_VAL(IDCODE), .L2_WORDS(256), .IR_W(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .jtag_tck_i  (tck),
    .jtag_trst_ni(trst_n),
    .jtag_tms_i  (tms),
    .jtag_tdi_i  (tdi),
    .jtag_tdo_o  (tdo)
  );

  always #5 clk = ~clk;

  // One TCK period: inputs change at the falling edge, tdo sampled just before rise
  task automatic step(input logic t_ms, input logic t_di, output logic o);
    tms = t_ms;
    tdi = t_di;
    #50;
    o = tdo;
    tck = 1'b1;
    #50;
    tck = 1'b0;
  endtask

  task automatic move(input logic t_ms);
    logic d;
    step(t_ms, 1'b0, d);
  endtask

  // From RTI: load IR, return captured IR bits, end in RTI
  task automatic scan_ir(input logic [4:0] ir, output logic [4:0] cap);
    logic o;
    move(1'b1); move(1'b1); move(1'b0); move(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(i == 4, ir[i], o);
      cap[i] = o;
    end
    move(1'b1); move(1'b0);
  endtask

  // From RTI: shift n DR bits LSB first, return captured bits, end in RTI
  task automatic scan_dr(input int n, input logic [64:0] din, output logic [64:0] dout);
    logic o;
    dout = '0;
    move(1'b1); move(1'b0); move(1'b0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], o);
      dout[i] = o;
    end
    move(1'b1); move(1'b0);
  endtask

  task automatic test_reset;
    trst_n = 1'b0;
    for (int i = 0; i < 5; i++) move(1'b1);
    trst_n = 1'b1;
    for (int i = 0; i < 5; i++) move(1'b1);
    n_total++;
    if (tdo !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_tdo got=%b exp=0", tdo);
    end
    move(1'b0);
  endtask

  task automatic test_idcode;
    logic [64:0] d;
    scan_dr(32, 65'd0, d);
    n_total++;
    if (d[31:0] !== IDCODE) begin
      n_bad++;
      $display("FAIL idcode got=%h exp=%h", d[31:0], IDCODE);
    end
  endtask

  task automatic test_ir_capture;
    logic [4:0] c;
    scan_ir(5'h01, c);
    n_total++;
    if (c !== 5'b00101) begin
      n_bad++;
      $display("FAIL ir_capture got=%b exp=00101", c);
    end
  endtask

  task automatic test_bypass;
    logic [4:0]  c;
    logic [64:0] d;
    scan_ir(5'h1F, c);
    scan_dr(9, {57'd0, 8'b1011_0010}, d);
    n_total++;
    if (d[8:0] !== 9'h164) begin
      n_bad++;
      $display("FAIL bypass got=%h exp=164", d[8:0]);
    end
    n_total++;
    if (tdo !== 1'b0) begin
      n_bad++;
      $display("FAIL bypass_idle_tdo got=%b exp=0", tdo);
    end
  endtask

  task automatic test_confreg;
    logic [4:0]  c;
    logic [64:0] d;
    scan_ir(5'h06, c);
    scan_dr(9, 65'h002, d);
    n_total++;
    if (d[8:0] !== 9'h000) begin
      n_bad++;
      $display("FAIL confreg_first got=%h exp=000", d[8:0]);
    end
    scan_dr(9, 65'h000, d);
    n_total++;
    if (d[8:0] !== 9'h002) begin
      n_bad++;
      $display("FAIL confreg_second got=%h exp=002", d[8:0]);
    end
  endtask

  task automatic test_tms_reset;
    logic [4:0]  c;
    logic [64:0] d;
    scan_ir(5'h1F, c);
    for (int i = 0; i < 5; i++) move(1'b1);
    move(1'b0);
    scan_dr(32, 65'd0, d);
    n_total++;
    if (d[31:0] !== IDCODE) begin
      n_bad++;
      $display("FAIL tms_reset_idcode got=%h exp=%h", d[31:0], IDCODE);
    end
  endtask

  task automatic test_memacc;
    logic [4:0]  c;
    logic [64:0] d;
    rst = 1'b0;
    scan_ir(5'h08, c);
    scan_dr(65, {32'hABBA_ABBA, 32'h0, 1'b1}, d);
    n_total++;
    if (d[0] !== 1'b0 || d[64:33] !== 32'h0) begin
      n_bad++;
      $display("FAIL mem_after_rst got done=%b rdata=%h exp done=0 rdata=0", d[0], d[64:33]);
    end
    scan_dr(65, {32'h0, 32'h0, 1'b0}, d);
    n_total++;
    if (d[0] !== 1'b1 || d[32:1] !== 32'h0) begin
      n_bad++;
      $display("FAIL mem_write_done got done=%b addr=%h exp done=1 addr=0", d[0], d[32:1]);
    end
    scan_dr(65, {32'h0, 32'h0, 1'b0}, d);
    n_total++;
    if (d !== {32'hABBA_ABBA, 32'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL mem_read0 got=%h exp=%h", d, {32'hABBA_ABBA, 32'h0, 1'b1});
    end
  endtask

  task automatic test_alias;
    logic [64:0] d;
    scan_dr(65, {32'h1234_5678, 32'h400, 1'b1}, d);
    scan_dr(65, {32'h0, 32'h0, 1'b0}, d);
    n_total++;
    if (d[32:1] !== 32'h400 || d[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL alias_last_addr got addr=%h done=%b exp addr=400 done=1", d[32:1], d[0]);
    end
    scan_dr(65, {32'h0, 32'h0, 1'b0}, d);
    n_total++;
    if (d !== {32'h1234_5678, 32'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL alias_read got=%h exp=%h", d, {32'h1234_5678, 32'h0, 1'b1});
    end
  endtask

  task automatic test_rst_write;
    logic [64:0] d;
    rst = 1'b1;
    scan_dr(65, {32'hDEAD_BEEF, 32'h0, 1'b1}, d);
    n_total++;
    if (d[0] !== 1'b0 || d[64:33] !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_capture got done=%b rdata=%h exp done=0 rdata=0", d[0], d[64:33]);
    end
    scan_dr(65, {32'h0, 32'h0, 1'b0}, d);
    n_total++;
    if (d[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_write_done got=%b exp=0", d[0]);
    end
    rst = 1'b0;
    scan_dr(65, {32'h0, 32'h0, 1'b0}, d);
    n_total++;
    if (d[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_release_done got=%b exp=0", d[0]);
    end
    scan_dr(65, {32'h0, 32'h0, 1'b0}, d);
    n_total++;
    if (d !== {32'h1234_5678, 32'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_mem_unchanged got=%h exp=%h", d, {32'h1234_5678, 32'h0, 1'b1});
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_idcode;
    test_ir_capture;
    test_bypass;
    test_confreg;
    test_tms_reset;
    test_memacc;
    test_alias;
    test_rst_write;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
